// File: rtl/serial_sub_ctrl_if.sv
// Request/response bundle between a requester and the bit-serial subtractor.
interface serial_sub_ctrl_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one 1-bit subtract cell (two half
// subtractors plus a borrow flop) walks the operands LSB first, then the
// completed difference and final borrow are published with a done strobe.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_sub_ctrl_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;

   logic             dbit;
   logic             nbr;
   logic [WIDTH-1:0] nxt_res;

   // Full subtract of one bit as two cascaded half subtractors.
   // Returns {borrow_out, difference}.
   function automatic logic [1:0] sub_bit(input logic x, input logic y,
                                          input logic bin);
      logic d1, b1, d, b2;
      d1 = x ^ y;
      b1 = ~x & y;
      d  = d1 ^ bin;
      b2 = ~d1 & bin;
      return {b1 | b2, d};
   endfunction

   // Insert a new bit at the MSB and drop the LSB; works for WIDTH=1 too.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                 input logic d);
      logic [WIDTH:0] t;
      t = {d, r};
      return t[WIDTH:1];
   endfunction

   // Current cell output and the result register as it will look after this bit.
   always_comb begin
      {nbr, dbit} = sub_bit(sa[0], sb[0], br);
      nxt_res     = shift_in(res, dbit);
   end

   // Sequencer: accept, shift WIDTH bits, publish result, strobe done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         diff_r <= '0;
         bout_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  sa     <= bus.a;
                  sb     <= bus.b;
                  br     <= 1'b0;
                  cnt    <= '0;
                  res    <= '0;
                  busy_r <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               res <= nxt_res;
               br  <= nbr;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  diff_r <= nxt_res;
                  bout_r <= nbr;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.diff = diff_r;
   assign bus.bout = bout_r;
endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial N-bit subtractor controller. It sequences a single one-bit subtract cell through WIDTH operand bits, least-significant bit first. The cell is two half-subtractor stages plus a borrow flip-flop. It accepts a start request, shifts operands, and returns the registered difference and final borrow with a one-cycle done strobe. It sits between a requester and the 1-bit subtract datapath, trading latency for area against a parallel WIDTH-bit subtractor.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle strobe; high while in DONE.
- diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH.
- bout  output  1  registered final borrow; 1 iff a < b (unsigned).

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on start=1.
  - SHIFT -> DONE when bit counter == WIDTH-1.
  - DONE -> IDLE unconditionally.
- On accept (IDLE with start=1):
  - load shift registers sa<=a, sb<=b;
  - clear borrow flip-flop br<=0;
  - clear counter cnt<=0;
  - clear result shift register.
- Each SHIFT edge, with x=sa[0], y=sb[0]:
  - stage 1: d1 = x^y, b1 = ~x&y;
  - stage 2: d = d1^br, b2 = ~d1&br;
  - br <= b1|b2;
  - d is shifted into the result register MSB-first, so bit i lands at position i after WIDTH shifts;
  - sa and sb shift right by 1; cnt increments.
- On the SHIFT->DONE edge, diff <= completed result and bout <= final borrow (b1|b2 of bit WIDTH-1).
- diff and bout hold their value until the next SHIFT->DONE edge or reset. They do not change during a new operation.
- start is ignored in SHIFT and DONE; there is no queuing.
- a and b may change freely after the accepting edge.
- Counter width is clog2(WIDTH), minimum 1 bit. WIDTH=1 goes SHIFT->DONE after a single shift edge.

## Timing
- Reset: async assert forces state=IDLE and busy=0, done=0, diff=0, bout=0, with all internal registers at 0. Release is clean on the next edge.
- Reset mid-operation aborts the operation. diff and bout return to 0, not to the previous result.
- Call the accepting edge E0:
  - busy=1 from E0 through E_WIDTH (exactly WIDTH cycles);
  - done=1 for the single cycle after E_WIDTH;
  - diff and bout are valid in that same cycle;
  - state returns to IDLE at E_WIDTH+1.
- Latency from start sampled to done high is WIDTH+1 edges. With WIDTH=8, done is high in the cycle after the 9th edge counting E0 as the 1st.
- Minimum issue interval: WIDTH+2 cycles.
  - start high during DONE is ignored.
  - start high in the following IDLE cycle is accepted.
- busy and done are never high simultaneously.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, start pulse -> busy high 8 cycles, then done 1 cycle with diff=0x37, bout=0.
- WIDTH=8, a=0x00, b=0x01 -> diff=0xFF, bout=1. Then a=0xAA, b=0xAA -> diff=0x00, bout=0. Then a=0xFF, b=0x00 -> diff=0xFF, bout=0.
- Issue 0x10-0x01. Hold start high and change a=0x80, b=0x7F during SHIFT and DONE -> exactly one done with diff=0x0F, bout=0. Hold start high one more cycle into IDLE -> second op accepted, done with diff=0x01, bout=0.
- Complete 0x5A-0x23 (diff=0x37). Start 0x03-0x09 and assert rst at the 4th SHIFT cycle -> immediate busy=0, done=0, diff=0x00, bout=0. After release, 0x03-0x09 -> diff=0xFA, bout=1.
- Retain the prior result: after diff=0x37, start 0x01-0x02 -> diff stays 0x37 throughout SHIFT, becomes 0xFF with bout=1 exactly in the done cycle.
- WIDTH=1 instance, all four (a,b) pairs:
  - (0,0) -> 0/0;
  - (1,0) -> 1/0;
  - (0,1) -> 1/1;
  - (1,1) -> 0/0;
  - each done arrives 2 edges after start.
